// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its companion detectors.
package seq_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default 3-bit pattern, also the target of the 101 detectors.
    localparam logic [2:0] PAT_101 = 3'b101;

    // A transmission is in progress while shifting bits or idling between repetitions.
    function automatic logic is_busy_state(input state_t s);
        return (s == SHIFT) || (s == GAP);
    endfunction

endpackage

// File: rtl/pattern_shift_unit.sv
// Holds the captured pattern and the index of the bit currently on the line.
// The index wraps back to the MSB after bit 0, so back-to-back repetitions and
// the return from a gap both start at the top without a separate reload.
module pattern_shift_unit #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_advance,
    output logic             o_last_bit,
    output logic             o_next_bit,
    output logic             o_next_first
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] r_pat_q;
    logic [IDX_W-1:0] r_bit_idx;
    logic [PAT_W-1:0] w_pat_nx;
    logic [IDX_W-1:0] w_idx_nx;

    // Next pattern/index: load takes the new pattern at the MSB, advance steps down and wraps.
    always_comb begin
        w_pat_nx = r_pat_q;
        w_idx_nx = r_bit_idx;
        if (i_load) begin
            w_pat_nx = i_pattern;
            w_idx_nx = IDX_TOP;
        end else if (i_advance) begin
            w_idx_nx = (r_bit_idx == '0) ? IDX_TOP : (r_bit_idx - IDX_W'(1));
        end
    end

    // The registered output stage in the top needs the bit that will be current after this edge.
    assign o_last_bit   = (r_bit_idx == '0);
    assign o_next_bit   = w_pat_nx[w_idx_nx];
    assign o_next_first = (w_idx_nx == IDX_TOP);

    // Bit index register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_bit_idx <= IDX_TOP;
        else          r_bit_idx <= w_idx_nx;
    end

    // Pattern shadow register; only meaningful after a load.
    always_ff @(posedge clk) begin
        r_pat_q <= w_pat_nx;
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first a programmed
// number of times with optional idle gaps, with a busy/done handshake.
// All outputs come straight from flops; their D inputs are decoded from the next state.
module seq_pattern_tx #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    import seq_pkg::*;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_reps_left;
    logic [CNT_W-1:0] w_reps_nx;
    logic [GAP_W-1:0] r_gap_q;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nx;
    logic             w_load;
    logic             w_advance;
    logic             w_last_bit;
    logic             w_next_bit;
    logic             w_next_first;
    logic             w_x_nx;
    logic             w_x_valid_nx;
    logic             w_frame_start_nx;
    logic             w_busy_nx;
    logic             w_done_nx;

    pattern_shift_unit #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_pattern    (pattern),
        .i_advance    (w_advance),
        .o_last_bit   (w_last_bit),
        .o_next_bit   (w_next_bit),
        .o_next_first (w_next_first)
    );

    // Next-state, counter and output decode; abort only matters while busy, so start wins in IDLE.
    always_comb begin
        w_state_nx   = r_state;
        w_reps_nx    = r_reps_left;
        w_gap_cnt_nx = r_gap_cnt;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_reps_nx  = repeat_cnt;
                    w_state_nx = (repeat_cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_advance = 1'b1;
                if (abort) begin
                    w_state_nx = DONE;
                end else if (w_last_bit) begin
                    if (r_reps_left == CNT_W'(1)) begin
                        w_state_nx = DONE;
                    end else begin
                        w_reps_nx = r_reps_left - CNT_W'(1);
                        if (r_gap_q != '0) begin
                            w_gap_cnt_nx = r_gap_q;
                            w_state_nx   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_nx = DONE;
                end else begin
                    w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
                    if (r_gap_cnt == GAP_W'(1)) w_state_nx = SHIFT;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        w_x_nx           = (w_state_nx == SHIFT) && w_next_bit;
        w_x_valid_nx     = (w_state_nx == SHIFT);
        w_frame_start_nx = (w_state_nx == SHIFT) && w_next_first;
        w_busy_nx        = is_busy_state(w_state_nx);
        w_done_nx        = (w_state_nx == DONE);
    end

    // State, repetition/gap counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_reps_left <= '0;
            r_gap_cnt   <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_reps_left <= w_reps_nx;
            r_gap_cnt   <= w_gap_cnt_nx;
            x           <= w_x_nx;
            x_valid     <= w_x_valid_nx;
            frame_start <= w_frame_start_nx;
            busy        <= w_busy_nx;
            done        <= w_done_nx;
        end
    end

    // Gap length shadow, captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) r_gap_q <= gap;
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a frame-level reference model predicts every output
// cycle, plus literal expectations for stream contents, counts and timing.
module tb_seq_pattern_tx;

    import seq_pkg::*;

    localparam int PAT_W = 3;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic [PAT_W-1:0] pattern    = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic [GAP_W-1:0] gap        = '0;
    logic             x, x_valid, frame_start, busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seq_pattern_tx #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .GAP_W (GAP_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap         (gap),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: one entry per output cycle, packed {x, x_valid, frame_start, busy, done}.
    logic [4:0] mq[$];
    logic [4:0] exp_o = 5'b0;

    task automatic build(input logic [PAT_W-1:0] p, input int reps, input int gp);
        if (reps == 0) begin
            mq.push_back(5'b00001);
        end else begin
            for (int r = 0; r < reps; r++) begin
                for (int b = PAT_W - 1; b >= 0; b--)
                    mq.push_back({p[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0});
                if (r < reps - 1)
                    for (int g = 0; g < gp; g++) mq.push_back(5'b00010);
            end
            mq.push_back(5'b00001);
        end
    endtask

    // Model advance at each edge; exp_o holds the expected outputs for the cycle that follows.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_o = 5'b0;
        end else begin
            if (exp_o[1] == 1'b0 && exp_o[0] == 1'b0 && mq.size() == 0 && start) begin
                build(pattern, int'(repeat_cnt), int'(gap));
            end else if (exp_o[1] && abort) begin
                mq.delete();
                mq.push_back(5'b00001);
            end
            if (mq.size() > 0) exp_o = mq.pop_front();
            else               exp_o = 5'b0;
        end
    end

    // Per-transaction observations.
    logic [31:0] s_stream;
    logic [2:0]  s_hist;
    int s_busy, s_valid, s_fs, s_done, s_det, s_done_at, s_ticks;

    task automatic clear_stats();
        s_stream  = '0;
        s_hist    = '0;
        s_busy    = 0;
        s_valid   = 0;
        s_fs      = 0;
        s_done    = 0;
        s_det     = 0;
        s_done_at = -1;
        s_ticks   = 0;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // One cycle: compare all outputs against the model on the falling edge, then record.
    task automatic tick();
        @(negedge clk);
        cyc++;
        checks++;
        if ({x, x_valid, frame_start, busy, done} !== exp_o) begin
            failures++;
            $display("FAIL cycle_model cyc=%0d x/vld/fs/busy/done got=%b required=%b",
                     cyc, {x, x_valid, frame_start, busy, done}, exp_o);
        end
        s_ticks++;
        if (busy) begin
            s_stream = {s_stream[30:0], x};
            s_busy++;
        end
        if (x_valid)     s_valid++;
        if (frame_start) s_fs++;
        if (done) begin
            s_done++;
            if (s_done_at < 0) s_done_at = s_ticks;
        end
        s_hist = {s_hist[1:0], x};
        if (s_hist == 3'b101) s_det++;
    endtask

    // Start a transmission from IDLE, scramble the inputs while busy, run to done plus one idle cycle.
    task automatic run_txn(input logic [PAT_W-1:0] p, input int reps, input int gp, input int budget);
        clear_stats();
        pattern    = p;
        repeat_cnt = reps[CNT_W-1:0];
        gap        = gp[GAP_W-1:0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
        pattern    = ~p;
        repeat_cnt = 8'd7;
        gap        = 4'd9;
        while (s_done == 0 && s_ticks < budget) tick();
        if (s_done == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_done ticks=%0d required=done within %0d", s_ticks, budget);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) tick();
        check_int("reset_outputs", int'({x, x_valid, frame_start, busy, done}), 0);
        reset_n = 1'b1;
        tick();

        // Single 101 repetition.
        run_txn(PAT_101, 1, 0, 20);
        check_int("t1_stream", int'(s_stream), 'b101);
        check_int("t1_valid", s_valid, 3);
        check_int("t1_fs", s_fs, 1);
        check_int("t1_done_at", s_done_at, 4);
        check_int("t1_busy", s_busy, 3);

        // Three back-to-back repetitions.
        run_txn(PAT_101, 3, 0, 40);
        check_int("t2_stream", int'(s_stream), 'b101101101);
        check_int("t2_valid", s_valid, 9);
        check_int("t2_fs", s_fs, 3);
        check_int("t2_det", s_det, 3);
        check_int("t2_done", s_done, 1);
        check_int("t2_done_at", s_done_at, 10);

        // Three repetitions with a one-cycle gap: 101 0 101 0 101 holds five overlapping 101s.
        run_txn(PAT_101, 3, 1, 40);
        check_int("t3_stream", int'(s_stream), 'b10101010101);
        check_int("t3_busy", s_busy, 11);
        check_int("t3_valid", s_valid, 9);
        check_int("t3_det", s_det, 5);
        check_int("t3_done_at", s_done_at, 12);

        // Zero repetitions with start held: done, idle, done again, idle.
        clear_stats();
        pattern    = PAT_101;
        repeat_cnt = '0;
        gap        = '0;
        start      = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        tick();
        check_int("t4_done_at", s_done_at, 1);
        check_int("t4_done_count", s_done, 2);
        check_int("t4_valid", s_valid, 0);
        check_int("t4_busy", s_busy, 0);

        // Abort on the second gap cycle of a 5x repetition with gap 2.
        clear_stats();
        pattern    = PAT_101;
        repeat_cnt = 8'd5;
        gap        = 4'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_int("t5_done_at", s_done_at, 6);
        check_int("t5_busy_at_done", int'(busy), 0);
        repeat (4) tick();
        check_int("t5_valid", s_valid, 3);
        check_int("t5_busy", s_busy, 5);
        check_int("t5_done_count", s_done, 1);

        // Abort together with the final bit gives a single done pulse.
        clear_stats();
        pattern    = PAT_101;
        repeat_cnt = 8'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check_int("t7_done_count", s_done, 1);
        check_int("t7_done_at", s_done_at, 4);

        // Start and abort together in IDLE: start wins.
        clear_stats();
        pattern    = 3'b110;
        repeat_cnt = 8'd2;
        gap        = 4'd0;
        start      = 1'b1;
        abort      = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (8) tick();
        check_int("t8_valid", s_valid, 6);
        check_int("t8_stream", int'(s_stream), 'b110110);
        check_int("t8_done_at", s_done_at, 7);

        // Asynchronous reset during the second bit, then a clean restart.
        clear_stats();
        pattern    = 3'b110;
        repeat_cnt = 8'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_int("t6_second_bit", int'({x, x_valid, busy}), 'b111);
        #2 reset_n = 1'b0;
        #1 check_int("t6_async_zero", int'({x, x_valid, frame_start, busy, done}), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_int("t6_no_done", s_done, 0);
        run_txn(3'b011, 1, 0, 20);
        check_int("t6_restart_stream", int'(s_stream), 'b011);
        check_int("t6_restart_fs", s_fs, 1);
        check_int("t6_restart_done_at", s_done_at, 4);

        // Maximum gap length.
        run_txn(3'b100, 2, 15, 60);
        check_int("t9_busy", s_busy, 21);
        check_int("t9_valid", s_valid, 6);
        check_int("t9_done_at", s_done_at, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
